gd_vector_timer: RTL
====================

# gd_vector_timer

Parametrised N-dimensional gradient-descent engine with built-in cycle, iteration and operation counters. It minimises f(x) = Σ(x_i − t_i)² in signed fixed point through one time-multiplexed datapath, one element per cycle. Host logic loads initial and target vectors, pulses `start` and reads the result vector and counters after `done`. It sits beside the existing scalar descent timer as the benchmark block for vector workloads.

## Interface
- `W`, 32: signed fixed-point word width (≥8).
- `FRAC_BITS`, 16: fractional bits; 1.0 = 2^FRAC_BITS.
- `N_DIM`, 4: vector length (≥1); `AW` = max(1, $clog2(N_DIM)).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; honoured only in IDLE or DONE.
- `lr` in W: learning rate, unsigned fixed point; sampled at `start`.
- `threshold` in W+1: unsigned convergence bound on |grad|; sampled at `start`.
- `max_iter` in 32: iteration limit; sampled at `start`.
- `wr_en` in 1: vector write strobe.
- `wr_sel` in 1: 0 = initial-x bank, 1 = target bank.
- `wr_addr` in AW: element index.
- `wr_data` in W: signed element value.
- `rd_addr` in AW: result element index.
- `rd_data` out W: working x[rd_addr], combinational.
- `busy` out 1: high in RUN/CHECK.
- `done` out 1: level, high in DONE.
- `converged` out 1: valid while `done`.
- `iter_count` out 32: completed iterations.
- `cycle_count` out 32: cycles spent in RUN+CHECK.
- `ops_count` out 32: arithmetic operations executed.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE. Reset enters IDLE and zeroes every output, every counter, both banks and working x.
- IDLE/DONE + `start`: copy init bank to working x, clear counters, `converged`, `done`, and the running max, capture `lr`/`threshold`/`max_iter`, then enter RUN with idx=0. If `max_iter`==0, go to DONE instead with `converged`=0 and all counters 0.
- RUN, element idx:
  - d = x_i − t_i, computed in W+1 bits.
  - g = 2d, computed in W+2 bits.
  - p = lr·g, 2W+2-bit signed product.
  - s = p >>> FRAC_BITS (arithmetic shift).
  - x_i ← x_i − s, truncated to W bits (see Configuration).
  - Running max of |g| updated.
  - `ops_count` += OPS_PER_ELEM (4).
  - idx = N_DIM−1 → CHECK; otherwise idx+1.
- CHECK: `iter_count`+1.
  - max|g| < `threshold` → DONE, `converged`=1.
  - Else new iter_count == `max_iter` → DONE, `converged`=0.
  - Else clear the max and go to RUN with idx=0.
- Convergence is judged on pre-update gradients of the final sweep. That sweep's update is still applied.
- `wr_en` is ignored while `busy`. Writes are accepted in IDLE/DONE and affect only the next `start`.
- `start` while `busy` is ignored.

## Timing
- `start` at edge k: `busy` high from k+1.
- One iteration = N_DIM RUN cycles + 1 CHECK cycle.
- `cycle_count` increments every RUN/CHECK cycle, so on completion it equals iter_count·(N_DIM+1).
- `done`, `converged` and the counters update on the same edge as the CHECK exit. Counters hold until the next `start`.
- `rd_data` reflects x updates on the edge after each RUN cycle.
- Counters wrap modulo 2^32.
- `rst_n` low mid-run: immediate return to IDLE with all state zeroed, no `done`.

## Configuration
- `GDT_SATURATE_EN` defined: x_i − s and the W-bit result clamp to [−2^(W−1), 2^(W−1)−1].
- `GDT_SATURATE_EN` undefined: two's-complement truncation (wrap). All other behaviour is identical.

## Structure
- Package `gdt_pkg`:
  - FSM state enum.
  - `OPS_PER_ELEM`=4.
  - Saturate/abs helper functions.
- Sub-module `gdt_elem_update`: combinational d/g/p/s/x_next datapath plus |g|. It is instantiated once and driven by idx.
- Top level: FSM, banks, counters.

## Test plan
All scenarios use W=32, FRAC_BITS=16, N_DIM=2.
- Init (5.0, −1.0), targets (3.0, 2.0), lr=0.5 (32768), thr=1, max_iter=100 → x becomes (3.0, 2.0) after iter 1. `done` with `converged`=1, iter_count=2, cycle_count=6, ops_count=16.
- Same vectors, lr=0, max_iter=3 → `converged`=0, iter_count=3, cycle_count=9, x unchanged (327680, −65536).
- Init x = t = 1.0, max_iter=5 → converged after 1 iteration, cycle_count=3.
- Init 0x7FFF0000, target −0x7FFF0000, lr=4.0 → with `GDT_SATURATE_EN`, x[0] clamps to 0x80000000 after the first sweep. Without it, x[0] equals the wrapped value computed by the model.
- `rst_n` pulsed low during iteration 2 → all outputs 0 on the next edge, IDLE; a subsequent `start` reproduces scenario 1 exactly.
- `start` and `wr_en` asserted while `busy` → both ignored. `start` in DONE restarts from the init bank with counters cleared.

Source files
------------

// File: rtl/gdt_pkg.sv
// Shared types and helpers for the gd_vector_timer gradient-descent engine.
// Optional clamping of x updates is enabled by defining GDT_SATURATE_EN.
package gdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int OPS_PER_ELEM = 4;

    // Wide scratch width for the helpers; covers the 2W+3-bit update path for W up to 64.
    localparam int GDT_WIDE = 132;

    typedef logic signed [GDT_WIDE-1:0] wide_t;

    function automatic wide_t sat_wide(input wide_t v, input int w);
        wide_t one;
        wide_t hi;
        wide_t lo;
        one = wide_t'(1);
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    function automatic wide_t abs_wide(input wide_t v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/gdt_elem_update.sv
// Combinational single-element descent step: x_next = x - ((lr * 2(x - t)) >>> FRAC_BITS), plus |g|.
// Defining GDT_SATURATE_EN clamps x_next to the signed W-bit range instead of wrapping.
module gdt_elem_update
    import gdt_pkg::*;
#(
    parameter int W         = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] t,
    input  logic        [W-1:0] lr,
    output logic signed [W-1:0] x_next,
    output logic        [W+1:0] g_abs
);

    localparam int PW = 2 * W + 2;

    logic signed [W:0]    d;
    logic signed [W+1:0]  g;
    logic signed [W:0]    lr_s;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] s;
    wide_t                diff_wide;
    wide_t                res_wide;
    wide_t                g_wide;

    // NOTE: every variable is assigned on every pass through always_comb, so no latch is inferred.
    always_comb begin
        d         = $signed({x[W-1], x}) - $signed({t[W-1], t});
        g         = $signed({d, 1'b0});
        lr_s      = $signed({1'b0, lr});
        // lr < 2^W and |g| <= 2^(W+1), so the product always fits 2W+2 signed bits.
        p         = PW'(lr_s) * PW'(g);
        s         = p >>> FRAC_BITS;
        diff_wide = wide_t'(x) - wide_t'(s);
`ifdef GDT_SATURATE_EN
        res_wide  = sat_wide(diff_wide, W);
`else
        res_wide  = diff_wide;
`endif
        x_next    = res_wide[W-1:0];
        g_wide    = abs_wide(wide_t'(g));
        g_abs     = g_wide[W+1:0];
    end

endmodule

// File: rtl/gd_vector_timer.sv
// N-dimensional gradient-descent engine with cycle/iteration/operation counters.
// Define GDT_SATURATE_EN to clamp x updates to the W-bit signed range (default wraps).
module gd_vector_timer
    import gdt_pkg::*;
#(
    parameter  int W         = 32,
    parameter  int FRAC_BITS = 16,
    parameter  int N_DIM     = 4,
    localparam int AW        = (N_DIM > 1) ? $clog2(N_DIM) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  lr,
    input  logic [W:0]    threshold,
    input  logic [31:0]   max_iter,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic [31:0]   iter_count,
    output logic [31:0]   cycle_count,
    output logic [31:0]   ops_count
);

    state_t              state;
    logic [AW-1:0]       idx;
    logic signed [W-1:0] init_bank [N_DIM];
    logic signed [W-1:0] tgt_bank  [N_DIM];
    logic signed [W-1:0] x_work    [N_DIM];
    logic [W-1:0]        lr_q;
    logic [W:0]          thr_q;
    logic [31:0]         max_iter_q;
    logic [W+1:0]        max_g;

    logic signed [W-1:0] x_next;
    logic [W+1:0]        g_abs;
    logic                idle_like;
    logic                last_idx;
    logic [31:0]         iter_next;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign last_idx  = (idx == AW'(N_DIM - 1));
    assign iter_next = iter_count + 32'd1;

    gdt_elem_update #(
        .W         (W),
        .FRAC_BITS (FRAC_BITS)
    ) u_elem (
        .x      (x_work[idx]),
        .t      (tgt_bank[idx]),
        .lr     (lr_q),
        .x_next (x_next),
        .g_abs  (g_abs)
    );

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < N_DIM)
            rd_data = x_work[rd_addr];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the banks and working vector are reset explicitly because a reset must leave no stale data.
            for (int i = 0; i < N_DIM; i++) begin
                init_bank[i] <= '0;
                tgt_bank[i]  <= '0;
                x_work[i]    <= '0;
            end
            state       <= ST_IDLE;
            idx         <= '0;
            lr_q        <= '0;
            thr_q       <= '0;
            max_iter_q  <= '0;
            max_g       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            iter_count  <= '0;
            cycle_count <= '0;
            ops_count   <= '0;
        end else begin
            if (wr_en && idle_like && (int'(wr_addr) < N_DIM)) begin
                if (wr_sel)
                    tgt_bank[wr_addr] <= wr_data;
                else
                    init_bank[wr_addr] <= wr_data;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_work      <= init_bank;
                        lr_q        <= lr;
                        thr_q       <= threshold;
                        max_iter_q  <= max_iter;
                        max_g       <= '0;
                        idx         <= '0;
                        converged   <= 1'b0;
                        iter_count  <= '0;
                        cycle_count <= '0;
                        ops_count   <= '0;
                        if (max_iter == 32'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    x_work[idx] <= x_next;
                    if (g_abs > max_g)
                        max_g <= g_abs;
                    ops_count   <= ops_count + 32'(OPS_PER_ELEM);
                    cycle_count <= cycle_count + 32'd1;
                    if (last_idx)
                        state <= ST_CHECK;
                    else
                        idx <= idx + AW'(1);
                end

                ST_CHECK: begin
                    cycle_count <= cycle_count + 32'd1;
                    iter_count  <= iter_next;
                    // Convergence uses the pre-update gradients of the sweep just finished.
                    if (max_g < {1'b0, thr_q}) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        converged <= 1'b1;
                    end else if (iter_next == max_iter_q) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        converged <= 1'b0;
                    end else begin
                        max_g <= '0;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
